// File: rtl/store_buffer.sv
// store_buffer: FIFO of retiring stores drained into data_mem when no load needs the port.
// Build with STBUF_FWD_EN defined to serve hitting loads from the buffer instead of stalling.
module store_buffer #(
  parameter int WORD  = 32,
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            st_valid,
  input  logic [WORD-1:0] st_addr,
  input  logic [WORD-1:0] st_data,
  input  logic            ld_req,
  input  logic [WORD-1:0] ld_addr,
  output logic [WORD-1:0] ld_data,
  output logic            stall,
  output logic [WORD-1:0] mem_addr,
  output logic [WORD-1:0] mem_wdata,
  output logic            mem_write,
  output logic            mem_read,
  input  logic [WORD-1:0] mem_rdata,
  output logic            empty
);

  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [WORD-1:0]  ent_addr [DEPTH];
  logic [WORD-1:0]  ent_data [DEPTH];
  logic [DEPTH-1:0] ent_vld;

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   count;

  logic full;
  logic hit;
  logic ld_wait;
  logic load_active;
  logic drain;
  logic enq;

`ifdef STBUF_FWD_EN
  logic [WORD-1:0] fwd_data;
`endif

  assign full        = (count == CNT_FULL);
  assign empty       = (count == '0);
  assign load_active = ld_req && !hit;
  assign drain       = (count != '0) && !load_active;
  assign enq         = st_valid && !full;

`ifdef STBUF_FWD_EN
  assign ld_wait = 1'b0;
`else
  assign ld_wait = ld_req && hit;
`endif

  assign stall = rst_n && ((st_valid && full) || ld_wait);

  // Scan oldest to youngest so the last match seen is the youngest one.
  always_comb begin
    hit = 1'b0;
`ifdef STBUF_FWD_EN
    fwd_data = '0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      logic [PTR_W-1:0] idx;
      idx = head + PTR_W'(i);
      if (ent_vld[idx] &&
          (ent_addr[idx][WORD-1:2] == ld_addr[WORD-1:2])) begin
        hit = 1'b1;
`ifdef STBUF_FWD_EN
        fwd_data = ent_data[idx];
`endif
      end
    end
  end

  // Memory port arbitration: a missing load owns the port, else drain head.
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = ld_addr;
    mem_wdata = '0;
    ld_data   = '0;
    if (!rst_n) begin
      mem_addr = '0;
    end else begin
      if (load_active) begin
        mem_read = 1'b1;
        ld_data  = mem_rdata;
      end else if (drain) begin
        mem_write = 1'b1;
        mem_addr  = ent_addr[head];
        mem_wdata = ent_data[head];
      end
`ifdef STBUF_FWD_EN
      if (ld_req && hit) begin
        ld_data = fwd_data;
      end
`endif
    end
  end

  // Head, tail and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) begin
        tail <= tail + PTR_ONE;
      end
      if (drain) begin
        head <= head + PTR_ONE;
      end
      unique case ({enq, drain})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Entry storage: retire at head, fill at tail.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_vld <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_addr[i] <= '0;
        ent_data[i] <= '0;
      end
    end else begin
      if (drain) begin
        ent_vld[head] <= 1'b0;
      end
      if (enq) begin
        ent_vld[tail]  <= 1'b1;
        ent_addr[tail] <= st_addr;
        ent_data[tail] <= st_data;
      end
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed stimulus plus a queue/architectural-memory model.
// The bench also plays data_mem (combinational read, commit on negedge).
module tb_store_buffer;

`ifdef STBUF_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        st_valid = 1'b0;
  logic [31:0] st_addr = '0;
  logic [31:0] st_data = '0;
  logic        ld_req = 1'b0;
  logic [31:0] ld_addr = '0;
  logic [31:0] ld_data;
  logic        stall;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] mem_rdata;
  logic        empty;

  int errors = 0;
  int checks = 0;

  logic [31:0] dmem [0:63] = '{default: 32'h0};
  logic [31:0] arch [0:63] = '{default: 32'h0};

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;
  ent_t q[$];

  logic        m_full;
  logic        m_hit;
  logic        m_read;
  logic        m_write;
  logic [31:0] m_ld;
  logic [31:0] m_addr;

  assign mem_rdata = dmem[mem_addr[7:2]];

  always #5 clk = ~clk;

  store_buffer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .st_valid  (st_valid),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .ld_req    (ld_req),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .stall     (stall),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_write (mem_write),
    .mem_read  (mem_read),
    .mem_rdata (mem_rdata),
    .empty     (empty)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: buffered stores in a queue, loads return the last accepted value.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      for (int i = 0; i < 64; i++) arch[i] = dmem[i];
    end else begin
      m_full = (q.size() == 4);
      m_hit  = 1'b0;
      foreach (q[i]) if (q[i].a[31:2] == ld_addr[31:2]) m_hit = 1'b1;
      m_read  = ld_req && !m_hit;
      m_write = (q.size() != 0) && !m_read;
      m_ld    = 32'h0;
      if (m_read || (ld_req && m_hit && FWD)) m_ld = arch[ld_addr[7:2]];
      m_addr = ld_addr;
      if (m_write) m_addr = q[0].a;
      chk("stall", {31'h0, stall},
          {31'h0, (st_valid && m_full) || (ld_req && m_hit && !FWD)});
      chk("mem_read", {31'h0, mem_read}, {31'h0, m_read});
      chk("mem_write", {31'h0, mem_write}, {31'h0, m_write});
      chk("mem_addr", mem_addr, m_addr);
      chk("ld_data", ld_data, m_ld);
      chk("empty", {31'h0, empty}, {31'h0, q.size() == 0});
      if (m_write) chk("mem_wdata", mem_wdata, q[0].d);
      if (mem_write) dmem[mem_addr[7:2]] = mem_wdata;
      if (m_write) void'(q.pop_front());
      if (st_valid && !m_full) begin
        q.push_back('{a: st_addr, d: st_data});
        arch[st_addr[7:2]] = st_data;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
  endtask

  task automatic wait_empty(input string nm);
    int n;
    n = 0;
    st_valid = 1'b0;
    @(negedge clk);
    while (!empty && n < 12) begin
      n++;
      tick();
      @(negedge clk);
    end
    chk(nm, {31'h0, empty}, 32'h1);
    tick();
  endtask

  initial begin
    int n;

    // Reset values.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_empty", {31'h0, empty}, 32'h1);
    chk("rst_stall", {31'h0, stall}, 32'h0);
    chk("rst_mem_write", {31'h0, mem_write}, 32'h0);
    chk("rst_mem_read", {31'h0, mem_read}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_ld_data", ld_data, 32'h0);
    #1 rst_n = 1'b1;
    tick();

    // Single store drains the next cycle.
    store(32'h10, 32'hDEADBEEF);
    tick();
    st_valid = 1'b0;
    @(negedge clk);
    chk("single_write", {31'h0, mem_write}, 32'h1);
    chk("single_addr", mem_addr, 32'h10);
    chk("single_wdata", mem_wdata, 32'hDEADBEEF);
    tick();
    @(negedge clk);
    chk("single_empty", {31'h0, empty}, 32'h1);
    chk("single_mem", dmem[4], 32'hDEADBEEF);
    tick();

    // Fill while a missing load holds the port.
    ld_req  = 1'b1;
    ld_addr = 32'h80;
    store(32'h0, 32'h11); tick();
    store(32'h4, 32'h22); tick();
    store(32'h8, 32'h33); tick();
    store(32'hC, 32'h44); tick();
    store(32'h20, 32'h55);
    @(negedge clk);
    chk("fill_stall", {31'h0, stall}, 32'h1);
    chk("fill_nodrain", {31'h0, mem_write}, 32'h0);
    tick();
    @(negedge clk);
    chk("fill_stall2", {31'h0, stall}, 32'h1);
    tick();
    ld_req = 1'b0;
    @(negedge clk);
    chk("fill_drain0", mem_addr, 32'h0);
    chk("fill_stall3", {31'h0, stall}, 32'h1);
    tick();
    @(negedge clk);
    chk("fill_accept", {31'h0, stall}, 32'h0);
    chk("fill_drain1", mem_addr, 32'h4);
    tick();
    wait_empty("fill_timeout");
    chk("fill_m0", dmem[0], 32'h11);
    chk("fill_m3", dmem[3], 32'h44);
    chk("fill_m20", dmem[8], 32'h55);

    // Two stores to one address, then a load while both are buffered.
    ld_req  = 1'b1;
    ld_addr = 32'h80;
    store(32'h40, 32'h1); tick();
    store(32'h40, 32'h2); tick();
    st_valid = 1'b0;
    ld_addr  = 32'h40;
`ifdef STBUF_FWD_EN
    @(negedge clk);
    chk("fwd_ld_data", ld_data, 32'h2);
    chk("fwd_stall", {31'h0, stall}, 32'h0);
    chk("fwd_mem_read", {31'h0, mem_read}, 32'h0);
    chk("fwd_drain_addr", mem_addr, 32'h40);
    chk("fwd_drain_data", mem_wdata, 32'h1);
    tick();
`else
    n = 0;
    @(negedge clk);
    while (stall && n < 8) begin
      n++;
      tick();
      @(negedge clk);
    end
    chk("nofwd_stall_cycles", n, 32'd2);
    chk("nofwd_mem_read", {31'h0, mem_read}, 32'h1);
    chk("nofwd_ld_data", ld_data, 32'h2);
    tick();
`endif
    ld_req = 1'b0;
    wait_empty("fwd_timeout");
    chk("fwd_mem", dmem[16], 32'h2);

    // Asynchronous reset in the middle of a drain.
    ld_req  = 1'b1;
    ld_addr = 32'h84;
    store(32'h60, 32'hA1); tick();
    store(32'h64, 32'hA2); tick();
    store(32'h68, 32'hA3); tick();
    st_valid = 1'b0;
    ld_req   = 1'b0;
    @(negedge clk);
    chk("mid_drain_addr", mem_addr, 32'h60);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_empty", {31'h0, empty}, 32'h1);
    chk("arst_write", {31'h0, mem_write}, 32'h0);
    chk("arst_read", {31'h0, mem_read}, 32'h0);
    chk("arst_stall", {31'h0, stall}, 32'h0);
    chk("arst_addr", mem_addr, 32'h0);
    chk("arst_wdata", mem_wdata, 32'h0);
    #1 rst_n = 1'b1;
    repeat (4) tick();
    chk("arst_m60", dmem[24], 32'hA1);
    chk("arst_m64", dmem[25], 32'h0);
    chk("arst_m68", dmem[26], 32'h0);

    // Plain loads from memory after reset.
    ld_req  = 1'b1;
    ld_addr = 32'h10;
    @(negedge clk);
    chk("ld_10", ld_data, 32'hDEADBEEF);
    tick();
    ld_addr = 32'h20;
    @(negedge clk);
    chk("ld_20", ld_data, 32'h55);
    tick();
    ld_req = 1'b0;
    repeat (2) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Store buffer between the EX/MEM pipeline register and data_mem, on the upstream side of data memory.
- Queues retiring stores in a small FIFO and drains them into data_mem on cycles when no load needs the shared memory address port.
- Loads are checked against buffered stores so that they always return the youngest value.
- Drives data_mem's read_addr / write_data / mem_write / mem_read and returns read data to the pipeline.

Parameters:
- WORD, 32, data and address width.
- DEPTH, 4, number of store entries; power of two, at least 2.
- PTR_W, 2, log2(DEPTH).

Ports:
- clk  in  1  pipeline clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- st_valid  in  1  store request from the MEM stage.
- st_addr  in  WORD  store byte address; word-aligned.
- st_data  in  WORD  store data.
- ld_req  in  1  load request from the MEM stage.
- ld_addr  in  WORD  load byte address; word-aligned.
- ld_data  out  WORD  load result to MEM/WB.
- stall  out  1  freezes IF..MEM for this cycle.
- mem_addr  out  WORD  to data_mem read_addr.
- mem_wdata  out  WORD  to data_mem write_data.
- mem_write  out  1  to data_mem mem_write.
- mem_read  out  1  to data_mem mem_read.
- mem_rdata  in  WORD  from data_mem read_data.
- empty  out  1  buffer holds no entries.

Behaviour:
- Storage:
  - Circular FIFO of DEPTH {addr, data} entries with head, tail and count (PTR_W+1 bits).
  - Pointers wrap modulo DEPTH.
  - full = (count == DEPTH).
- Reset (async, rst_n=0):
  - head=tail=count=0 and all entries invalid.
  - Outputs: empty=1, stall=0, mem_write=0, mem_read=0, mem_addr=0, mem_wdata=0, ld_data=0.
  - A reset mid-drain discards all buffered stores.
- Match:
  - An entry matches when entry.addr[WORD-1:2] == ld_addr[WORD-1:2].
  - hit is true when any valid entry matches; the youngest matching entry (closest to tail) wins.
- ld_wait (combinational): ld_req && hit && forwarding disabled (see Optional Feature); 0 otherwise.
- stall = (st_valid && full) || ld_wait. stall is combinational, with no added latency.
- Memory port arbitration, evaluated each cycle:
  - Load active (ld_req && !ld_wait && !hit):
    - mem_read=1, mem_addr=ld_addr, mem_write=0, ld_data=mem_rdata.
    - This is a zero-cycle combinational read.
  - Load forwarded (ld_req && hit, forwarding enabled):
    - ld_data = youngest match data, mem_read=0.
    - The memory port is free, so a drain may proceed.
  - Drain:
    - Occurs when count>0 and the port is not claimed by an active load.
    - mem_write=1, mem_addr=head.addr, mem_wdata=head.data.
    - data_mem commits on the negedge; head advances on the following posedge.
  - Idle: mem_write=0, mem_read=0, mem_addr=ld_addr, ld_data=0.
- Enqueue: on posedge, if st_valid && !full, write the entry at tail and advance tail.
- Simultaneous enqueue and drain: count unchanged; both pointers advance.
- Full with st_valid: stall=1 and the store is not accepted.
  - A drain in the same cycle frees a slot; the store is accepted on the next cycle.
  - No same-cycle bypass into a full buffer.
- ld_wait never blocks draining, so a stalled load always makes progress.
  - Once the matching entries retire, hit falls and the load proceeds from memory.
- A store and a load to the same address in one cycle cannot occur: the MEM stage issues one operation per cycle.
- empty = (count == 0).

Optional Feature:
- Macro: STBUF_FWD_EN.
- Defined: loads hitting the buffer are served from the youngest matching entry with no stall (ld_wait=0).
- Undefined: a load that hits asserts ld_wait/stall until no matching entry remains, then reads data_mem.
  - Forwarding mux logic is compiled out.

Test Plan:
- Reset: hold rst_n=0, then release -> empty=1, stall=0, mem_write=0, mem_read=0.
- Single store: st_valid with addr 0x10, data 0xDEADBEEF, then idle.
  - Next cycle: mem_write=1, mem_addr=0x10, mem_wdata=0xDEADBEEF.
  - data_mem bytes 0x10..0x13 = DE AD BE EF; empty=1 after.
- Fill: with ld_req held to a non-matching address, issue 5 back-to-back stores (0x0, 0x4, 0x8, 0xC, 0x20).
  - The 5th asserts stall; no drain occurs while the load holds the port.
  - Releasing ld_req drains entries in order 0x0, 0x4, 0x8, 0xC, then 0x20.
- Forward (STBUF_FWD_EN): store 0x40 := 1, then 0x40 := 2, then ld 0x40 the same cycle the buffer still holds both.
  - ld_data=2, stall=0, mem_read=0.
- No forward (macro undefined): same sequence.
  - stall=1 for the cycles needed to drain both entries; then mem_read=1 and ld_data=2 from memory.
- Async reset mid-drain: 3 entries buffered, pulse rst_n low between edges.
  - Outputs clear immediately; the remaining 2 stores are never written.
